// File: rtl/omsp_multitimer_pkg.sv
// Shared constants and helpers for the openMSP430 multi-channel interval timer.
// Word offsets are relative to the 128-byte block base.
package omsp_multitimer_pkg;

  localparam int DEC_W = 7;

  localparam logic [5:0] WOFF_GCTL  = 6'h00;
  localparam logic [5:0] WOFF_PRESC = 6'h01;
  localparam logic [5:0] WOFF_IE    = 6'h02;
  localparam logic [5:0] WOFF_IFG   = 6'h03;

  // Channel c occupies word offsets {CH_BASE + c, reg}.
  localparam logic [3:0] CH_BASE = 4'h4;

  localparam int CTL_EN      = 0;
  localparam int CTL_ONESHOT = 1;

  typedef enum logic [1:0] {
    CH_CTL    = 2'd0,
    CH_RELOAD = 2'd1,
    CH_COUNT  = 2'd2,
    CH_RSVD   = 2'd3
  } ch_reg_e;

  function automatic logic [15:0] lane_merge(input logic [15:0] old,
                                             input logic [15:0] din,
                                             input logic [1:0]  we);
    lane_merge = {(we[1] ? din[15:8] : old[15:8]), (we[0] ? din[7:0] : old[7:0])};
  endfunction

endpackage

// File: rtl/omsp_multitimer_chan.sv
// One down-counting timer channel: EN/ONESHOT control, reload and count
// registers, and the expiry pulse raised on the tick that finds COUNT at zero.
module omsp_multitimer_chan
  import omsp_multitimer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             mclk,
  input  logic             puc_rst,
  input  logic             tick,
  input  logic             wr_ctl,
  input  logic             wr_reload,
  input  logic             wr_count,
  input  logic [1:0]       we,
  input  logic [15:0]      din,
  output logic             en,
  output logic             oneshot,
  output logic [CNT_W-1:0] reload,
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  logic             en_r, oneshot_r, en_nxt_s, oneshot_nxt_s, expire_s;
  logic [CNT_W-1:0] reload_r, count_r, reload_nxt_s, count_nxt_s;
  logic [15:0]      count_wr_s, reload_wr_s;

  assign count_wr_s  = lane_merge(16'(count_r), din, we);
  assign reload_wr_s = lane_merge(16'(reload_r), din, we);

  // Next-state: a CTL or COUNT write pre-empts this channel's tick.
  always_comb begin
    en_nxt_s      = en_r;
    oneshot_nxt_s = oneshot_r;
    count_nxt_s   = count_r;
    expire_s      = 1'b0;
    if (wr_ctl) begin
      en_nxt_s      = we[0] ? din[CTL_EN] : en_r;
      oneshot_nxt_s = we[0] ? din[CTL_ONESHOT] : oneshot_r;
      if (en_nxt_s && !en_r) begin
        count_nxt_s = reload_r;
      end else begin
        count_nxt_s = count_r;
      end
    end else if (wr_count) begin
      count_nxt_s = count_wr_s[CNT_W-1:0];
    end else if (tick && en_r) begin
      if (count_r != {CNT_W{1'b0}}) begin
        count_nxt_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        expire_s    = 1'b1;
        count_nxt_s = reload_r;
        en_nxt_s    = en_r & ~oneshot_r;
      end
    end else begin
      count_nxt_s = count_r;
    end
    if (wr_reload) begin
      reload_nxt_s = reload_wr_s[CNT_W-1:0];
    end else begin
      reload_nxt_s = reload_r;
    end
  end

  // Channel state registers.
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      en_r      <= 1'b0;
      oneshot_r <= 1'b0;
      reload_r  <= {CNT_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
    end else begin
      en_r      <= en_nxt_s;
      oneshot_r <= oneshot_nxt_s;
      reload_r  <= reload_nxt_s;
      count_r   <= count_nxt_s;
    end
  end

  assign en      = en_r;
  assign oneshot = oneshot_r;
  assign reload  = reload_r;
  assign count   = count_r;
  assign expire  = expire_s;

endmodule

// File: rtl/omsp_multitimer.sv
// N-channel interval timer peripheral for the openMSP430 bus: decode, shared
// prescaler, IE/IFG with acknowledge priority, and the read-back mux.
module omsp_multitimer
  import omsp_multitimer_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR = 15'h0100,
  parameter int          NCH       = 4,
  parameter int          CNT_W     = 16
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  input  logic        irq_acc,
  output logic [15:0] per_dout,
  output logic        irq
);

  logic [DEC_W-2:0] woff_s;
  logic             sel_s, wr_s, rd_s, wr_gctl_s, wr_presc_s, wr_ie_s, wr_ifg_s, tick_s;
  logic             gen_r, irq_r, acc_found_s;
  logic [15:0]      presc_r, pcnt_r, rdata_s;
  logic [NCH-1:0]   ie_r, ifg_r, ie_nxt_s, ifg_nxt_s, pend_s, acc_clr_s, w1c_s;
  logic [NCH-1:0]   en_s, oneshot_s, expire_s;
  logic [CNT_W-1:0] reload_s [NCH];
  logic [CNT_W-1:0] count_s  [NCH];

  assign sel_s      = per_en & (per_addr[13:6] == BASE_ADDR[14:7]);
  assign woff_s     = per_addr[5:0];
  assign wr_s       = sel_s & (per_we != 2'b00);
  assign rd_s       = sel_s & (per_we == 2'b00);
  assign wr_gctl_s  = wr_s & (woff_s == WOFF_GCTL);
  assign wr_presc_s = wr_s & (woff_s == WOFF_PRESC);
  assign wr_ie_s    = wr_s & (woff_s == WOFF_IE);
  assign wr_ifg_s   = wr_s & (woff_s == WOFF_IFG);
  assign tick_s     = gen_r & (pcnt_r == presc_r);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic hit_s;
    assign hit_s = wr_s & (woff_s[5:2] == (CH_BASE + 4'(c)));
    omsp_multitimer_chan #(.CNT_W(CNT_W)) u_chan (
      .mclk      (mclk),
      .puc_rst   (puc_rst),
      .tick      (tick_s),
      .wr_ctl    (hit_s & (ch_reg_e'(woff_s[1:0]) == CH_CTL)),
      .wr_reload (hit_s & (ch_reg_e'(woff_s[1:0]) == CH_RELOAD)),
      .wr_count  (hit_s & (ch_reg_e'(woff_s[1:0]) == CH_COUNT)),
      .we        (per_we),
      .din       (per_din),
      .en        (en_s[c]),
      .oneshot   (oneshot_s[c]),
      .reload    (reload_s[c]),
      .count     (count_s[c]),
      .expire    (expire_s[c])
    );
  end

  // Global control and prescaler; GEN=0 or a PRESC write parks pcnt at zero.
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      gen_r   <= 1'b0;
      presc_r <= 16'h0000;
      pcnt_r  <= 16'h0000;
    end else begin
      if (wr_gctl_s && per_we[0]) gen_r <= per_din[0];
      if (wr_presc_s) presc_r <= lane_merge(presc_r, per_din, per_we);
      if (wr_presc_s || !gen_r || tick_s) pcnt_r <= 16'h0000;
      else pcnt_r <= pcnt_r + 16'h0001;
    end
  end

  // Flag next-state: acknowledge clears the lowest pending enabled flag, expiry beats any clear.
  always_comb begin
    pend_s      = ifg_r & ie_r;
    acc_clr_s   = '0;
    acc_found_s = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (irq_acc && pend_s[i] && !acc_found_s) begin
        acc_clr_s[i] = 1'b1;
        acc_found_s  = 1'b1;
      end else begin
        acc_clr_s[i] = 1'b0;
      end
    end
    w1c_s     = (wr_ifg_s && per_we[0]) ? per_din[NCH-1:0] : '0;
    ie_nxt_s  = (wr_ie_s && per_we[0]) ? per_din[NCH-1:0] : ie_r;
    ifg_nxt_s = (ifg_r & ~(w1c_s | acc_clr_s)) | expire_s;
  end

  // IE/IFG registers; irq follows the next-state flags.
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      ie_r  <= '0;
      ifg_r <= '0;
      irq_r <= 1'b0;
    end else begin
      ie_r  <= ie_nxt_s;
      ifg_r <= ifg_nxt_s;
      irq_r <= |(ifg_nxt_s & ie_nxt_s);
    end
  end

  // Read mux; channel blocks start above the global registers so the two never overlap.
  always_comb begin
    case (woff_s)
      WOFF_GCTL:  rdata_s = {15'h0000, gen_r};
      WOFF_PRESC: rdata_s = presc_r;
      WOFF_IE:    rdata_s = 16'(ie_r);
      WOFF_IFG:   rdata_s = 16'(ifg_r);
      default:    rdata_s = 16'h0000;
    endcase
    for (int c = 0; c < NCH; c++) begin
      if (woff_s[5:2] == (CH_BASE + 4'(c))) begin
        case (ch_reg_e'(woff_s[1:0]))
          CH_CTL:    rdata_s = {14'h0000, oneshot_s[c], en_s[c]};
          CH_RELOAD: rdata_s = 16'(reload_s[c]);
          CH_COUNT:  rdata_s = 16'(count_s[c]);
          default:   rdata_s = 16'h0000;
        endcase
      end else begin
        rdata_s = rdata_s;
      end
    end
  end

  assign per_dout = rd_s ? rdata_s : 16'h0000;
  assign irq      = irq_r;

endmodule
